id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of register-data, immediate and PC fields.
REQ-002 SHALL have parameter REG_AW, default 5, width of register-address fields.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk_i  in  1  rising-edge clock.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 stall_i  in  1  hold all outputs this cycle.
REQ-006 flush_i  in  1  replace the captured instruction with a bubble.
REQ-007 valid_i  in  1  ID stage holds a real instruction.
REQ-008 ALUOp_i  in  2; ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each: decoded control from ID.
REQ-009 RS1data_i, RS2data_i, imm_i, pc_i  in  DATA_W each: operands, sign-extended immediate, instruction PC.
REQ-010 funct_i  in  10  {funct7, funct3}.
REQ-011 RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW each.
REQ-012 Outputs: one registered _o per input of REQ-007..REQ-011, same width, plus bubble_cnt_o  out  16  saturating bubble count.

Function
REQ-013 All outputs SHALL be flop outputs; no combinational input-to-output path.
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on outputs after edge N.
REQ-015 Per-edge priority SHALL be rst_i > flush_i > stall_i > normal load.
REQ-016 Normal load (no rst/flush/stall): every field captures its input.
REQ-017 On normal load with valid_i=0: valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemToReg_o, ALUSrc_o SHALL be 0, ALUOp_o SHALL be 2'b00; data/address fields capture inputs.
REQ-018 On normal load with RDaddr_i=0: RegWrite_o SHALL be captured as 0 regardless of RegWrite_i (x0 never written).
REQ-019 Stall: every output, including bubble_cnt_o, SHALL hold its previous value.
REQ-020 Flush: all control outputs and valid_o SHALL be 0; all data, address, funct, pc fields SHALL be 0.
REQ-021 flush_i and stall_i both high: flush SHALL win (bubble inserted, counter updated).
REQ-022 bubble_cnt_o SHALL increment by 1 on each non-reset edge where a bubble is latched (flush, or normal load with valid_i=0).
REQ-023 bubble_cnt_o SHALL saturate at 16'hFFFF and never wrap.
REQ-024 stall_i held for any number of cycles SHALL not alter state; load resumes the cycle stall_i drops.

Reset
REQ-025 On a rising edge with rst_i=1, every output including bubble_cnt_o SHALL become 0, regardless of stall_i/flush_i.
REQ-026 rst_i asserted mid-stall or mid-flush SHALL take effect on that edge; first load occurs on the first edge with rst_i=0.
REQ-027 Outputs SHALL be undefined only before the first reset edge; benches SHALL reset before checking.

Verification
REQ-028 Load: valid_i=1, RegWrite_i=1, RDaddr_i=5, RS1data_i=32'h1234, ALUOp_i=2'b01 -> next cycle RegWrite_o=1, RDaddr_o=5, RS1data_o=32'h1234, ALUOp_o=2'b01, bubble_cnt_o unchanged.
REQ-029 x0 guard: RegWrite_i=1, RDaddr_i=0, valid_i=1 -> RegWrite_o=0, valid_o=1.
REQ-030 Stall: load pc_i=32'h10, then stall 3 cycles while pc_i=32'h14 -> pc_o stays 32'h10 three cycles, becomes 32'h14 one cycle after stall_i drops.
REQ-031 Flush+stall together with MemWrite_i=1 -> MemWrite_o=0, valid_o=0, pc_o=0, bubble_cnt_o +1.
REQ-032 Saturation: 65 540 consecutive flush cycles -> bubble_cnt_o=16'hFFFF, stays there.
REQ-033 Reset mid-operation: rst_i=1 with stall_i=1 and nonzero outputs -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_register.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_register
//  Purpose  : ID/EX pipeline register with stall, flush-to-bubble and a
//             saturating bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [9:0]        funct_i,
    input  logic [REG_AW-1:0] RS1addr_i,
    input  logic [REG_AW-1:0] RS2addr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    output logic              valid_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [9:0]        funct_o,
    output logic [REG_AW-1:0] RS1addr_o,
    output logic [REG_AW-1:0] RS2addr_o,
    output logic [REG_AW-1:0] RDaddr_o,
    output logic [15:0]       bubble_cnt_o
);

    logic              r_valid;
    logic [1:0]        r_alu_op;
    logic              r_alu_src;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [9:0]        r_funct;
    logic [REG_AW-1:0] r_rs1_addr;
    logic [REG_AW-1:0] r_rs2_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic [15:0]       r_bubble_cnt;

    logic [15:0]       w_cnt_next;
    logic              w_rd_nonzero;

    assign w_cnt_next   = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;
    assign w_rd_nonzero = (RDaddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_alu_op     <= 2'b00;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_funct      <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_rd_addr    <= '0;
            r_bubble_cnt <= 16'd0;
        end else if (flush_i) begin
            // Flush overrides stall: a full zero bubble is always latched.
            r_valid      <= 1'b0;
            r_alu_op     <= 2'b00;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_funct      <= '0;
            r_rs1_addr   <= '0;
            r_rs2_addr   <= '0;
            r_rd_addr    <= '0;
            r_bubble_cnt <= w_cnt_next;
        end else if (!stall_i) begin
            // Control is gated by valid; data fields load unconditionally.
            r_valid      <= valid_i;
            r_alu_op     <= valid_i ? ALUOp_i : 2'b00;
            r_alu_src    <= valid_i & ALUSrc_i;
            r_reg_write  <= valid_i & RegWrite_i & w_rd_nonzero;
            r_mem_to_reg <= valid_i & MemToReg_i;
            r_mem_read   <= valid_i & MemRead_i;
            r_mem_write  <= valid_i & MemWrite_i;
            r_rs1_data   <= RS1data_i;
            r_rs2_data   <= RS2data_i;
            r_imm        <= imm_i;
            r_pc         <= pc_i;
            r_funct      <= funct_i;
            r_rs1_addr   <= RS1addr_i;
            r_rs2_addr   <= RS2addr_i;
            r_rd_addr    <= RDaddr_i;
            if (!valid_i) begin
                r_bubble_cnt <= w_cnt_next;
            end
        end
    end

    assign valid_o      = r_valid;
    assign ALUOp_o      = r_alu_op;
    assign ALUSrc_o     = r_alu_src;
    assign RegWrite_o   = r_reg_write;
    assign MemToReg_o   = r_mem_to_reg;
    assign MemRead_o    = r_mem_read;
    assign MemWrite_o   = r_mem_write;
    assign RS1data_o    = r_rs1_data;
    assign RS2data_o    = r_rs2_data;
    assign imm_o        = r_imm;
    assign pc_o         = r_pc;
    assign funct_o      = r_funct;
    assign RS1addr_o    = r_rs1_addr;
    assign RS2addr_o    = r_rs2_addr;
    assign RDaddr_o     = r_rd_addr;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_register
//  Purpose  : Directed, table-driven self-checking bench for id_ex_register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_register;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid;
    logic [1:0]  alu_op;
    logic        alu_src, reg_write, mem_to_reg, mem_read, mem_write;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic [9:0]  funct;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;

    logic        valid_o, alu_src_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o;
    logic [1:0]  alu_op_o;
    logic [31:0] rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic [9:0]  funct_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [15:0] cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .ALUOp_i(alu_op), .ALUSrc_i(alu_src), .RegWrite_i(reg_write),
        .MemToReg_i(mem_to_reg), .MemRead_i(mem_read), .MemWrite_i(mem_write),
        .RS1data_i(rs1_data), .RS2data_i(rs2_data), .imm_i(imm), .pc_i(pc),
        .funct_i(funct), .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr), .RDaddr_i(rd_addr),
        .valid_o(valid_o), .ALUOp_o(alu_op_o), .ALUSrc_o(alu_src_o), .RegWrite_o(reg_write_o),
        .MemToReg_o(mem_to_reg_o), .MemRead_o(mem_read_o), .MemWrite_o(mem_write_o),
        .RS1data_o(rs1_data_o), .RS2data_o(rs2_data_o), .imm_o(imm_o), .pc_o(pc_o),
        .funct_o(funct_o), .RS1addr_o(rs1_addr_o), .RS2addr_o(rs2_addr_o), .RDaddr_o(rd_addr_o),
        .bubble_cnt_o(cnt_o)
    );

    typedef struct {
        logic        stall, flush, valid, rw;
        logic [4:0]  rd;
        logic [31:0] rs1, pc;
        logic [1:0]  aluop;
        logic        mw;
        logic        e_valid, e_rw;
        logic [4:0]  e_rd;
        logic [31:0] e_rs1, e_pc;
        logic [1:0]  e_aluop;
        logic        e_mw;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [12];

    // Secondary fields are tied to rs1/pc/rd so that a zero bubble maps to zero.
    function automatic logic [31:0] f_rs2(input logic [31:0] a);
        return a * 32'd3;
    endfunction
    function automatic logic [9:0] f_funct(input logic [31:0] a, input logic [31:0] p);
        return a[9:0] ^ p[9:0];
    endfunction
    function automatic logic [4:0] f_ra1(input logic [4:0] r);
        return r * 5'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] p,
                         input logic [1:0] op, input logic mw);
        stall = st; flush = fl; valid = v; reg_write = rw; rd_addr = rd;
        rs1_data = r1; pc = p; alu_op = op; mem_write = mw;
        alu_src = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1;
        rs2_data = f_rs2(r1); imm = p << 1; funct = f_funct(r1, p);
        rs1_addr = f_ra1(rd); rs2_addr = rd << 1;
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, " valid"},    {31'd0, valid_o},      {31'd0, e.e_valid});
        chk({tag, " regwrite"}, {31'd0, reg_write_o},  {31'd0, e.e_rw});
        chk({tag, " rd"},       {27'd0, rd_addr_o},    {27'd0, e.e_rd});
        chk({tag, " rs1data"},  rs1_data_o,            e.e_rs1);
        chk({tag, " pc"},       pc_o,                  e.e_pc);
        chk({tag, " aluop"},    {30'd0, alu_op_o},     {30'd0, e.e_aluop});
        chk({tag, " memwrite"}, {31'd0, mem_write_o},  {31'd0, e.e_mw});
        chk({tag, " bubbles"},  {16'd0, cnt_o},        {16'd0, e.e_cnt});
        chk({tag, " alusrc"},   {31'd0, alu_src_o},    {31'd0, e.e_valid});
        chk({tag, " memtoreg"}, {31'd0, mem_to_reg_o}, {31'd0, e.e_valid});
        chk({tag, " memread"},  {31'd0, mem_read_o},   {31'd0, e.e_valid});
        chk({tag, " rs2data"},  rs2_data_o,            f_rs2(e.e_rs1));
        chk({tag, " imm"},      imm_o,                 e.e_pc << 1);
        chk({tag, " funct"},    {22'd0, funct_o},      {22'd0, f_funct(e.e_rs1, e.e_pc)});
        chk({tag, " rs1addr"},  {27'd0, rs1_addr_o},   {27'd0, f_ra1(e.e_rd)});
        chk({tag, " rs2addr"},  {27'd0, rs2_addr_o},   {27'd0, e.e_rd << 1});
    endtask

    vec_t zero_v;
    vec_t tmp_v;

    initial begin
        // stall flush valid rw rd rs1 pc aluop mw | e_valid e_rw e_rd e_rs1 e_pc e_aluop e_mw e_cnt
        vecs[0]  = '{1'b0,1'b0,1'b1,1'b1,5'd5, 32'h1234,32'h0, 2'b01,1'b0, 1'b1,1'b1,5'd5, 32'h1234,32'h0, 2'b01,1'b0,16'd0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,5'd0, 32'hAAAA,32'h4, 2'b10,1'b1, 1'b1,1'b0,5'd0, 32'hAAAA,32'h4, 2'b10,1'b1,16'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,5'd7, 32'h5555,32'h8, 2'b11,1'b1, 1'b0,1'b0,5'd7, 32'h5555,32'h8, 2'b00,1'b0,16'd1};
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b1,5'd3, 32'h1,   32'h10,2'b10,1'b0, 1'b1,1'b1,5'd3, 32'h1,   32'h10,2'b10,1'b0,16'd1};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,5'd9, 32'h2,   32'h14,2'b01,1'b1, 1'b1,1'b1,5'd3, 32'h1,   32'h10,2'b10,1'b0,16'd1};
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,5'd9, 32'h2,   32'h14,2'b01,1'b1, 1'b1,1'b1,5'd9, 32'h2,   32'h14,2'b01,1'b1,16'd1};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,5'd4, 32'hF,   32'h18,2'b11,1'b1, 1'b0,1'b0,5'd0, 32'h0,   32'h0, 2'b00,1'b0,16'd2};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b1,5'd6, 32'hE,   32'h1C,2'b01,1'b1, 1'b0,1'b0,5'd0, 32'h0,   32'h0, 2'b00,1'b0,16'd3};
        vecs[10] = '{1'b1,1'b0,1'b1,1'b1,5'd8, 32'hD,   32'h20,2'b10,1'b1, 1'b0,1'b0,5'd0, 32'h0,   32'h0, 2'b00,1'b0,16'd3};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b0,5'd31,32'hFFFFFFFF,32'h24,2'b11,1'b0, 1'b1,1'b0,5'd31,32'hFFFFFFFF,32'h24,2'b11,1'b0,16'd3};
        zero_v   = '{1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,32'h0,2'b00,1'b0, 1'b0,1'b0,5'd0, 32'h0,32'h0,2'b00,1'b0,16'd0};

        // Reset state
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h99, 32'h40, 2'b01, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("reset", zero_v);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rw, vecs[i].rd,
                  vecs[i].rs1, vecs[i].pc, vecs[i].aluop, vecs[i].mw);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while stalled with nonzero outputs
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h77, 32'h30, 2'b01, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("rst_stall", zero_v);

        // Reset while flushing: counter must stay 0, not bump
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h77, 32'h30, 2'b01, 1'b1);
        @(posedge clk); #1;
        check_all("rst_flush", zero_v);

        // First edge after reset loads
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h77, 32'h30, 2'b01, 1'b1);
        @(posedge clk); #1;
        tmp_v = '{1'b0,1'b0,1'b1,1'b1,5'd2, 32'h77,32'h30,2'b01,1'b1, 1'b1,1'b1,5'd2, 32'h77,32'h30,2'b01,1'b1,16'd0};
        check_all("post_rst_load", tmp_v);

        // Saturation of the bubble counter
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h77, 32'h30, 2'b01, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, cnt_o}, 32'h0000FFFE);
        @(posedge clk); #1;
        chk("sat_ffff", {16'd0, cnt_o}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold_flush", {16'd0, cnt_o}, 32'h0000FFFF);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h77, 32'h30, 2'b01, 1'b1);
        @(posedge clk); #1;
        chk("sat_hold_invalid", {16'd0, cnt_o}, 32'h0000FFFF);
        chk("sat_invalid_pc", pc_o, 32'h30);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("sat_reset", {16'd0, cnt_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
